// File: rtl/traffic_light_ctrl.sv
// Two-street traffic light controller.
// Moore FSM that cycles A-green -> A-yellow -> B-green -> B-yellow. All
// timing is measured in upstream tick strobes. A green phase is held while
// cars wait on that street, and always lasts at least MIN_GREEN_TICKS.
// Each yellow phase lasts exactly YELLOW_TICKS.
module traffic_light_ctrl #(
  parameter int unsigned YELLOW_TICKS    = 5,
  parameter int unsigned MIN_GREEN_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S0 = 2'd0,  // A green,  B red
    S1 = 2'd1,  // A yellow, B red
    S2 = 2'd2,  // A red,    B green
    S3 = 2'd3   // A red,    B yellow
  } state_t;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // Counter thresholds are precomputed at 8 bits so they compare cleanly
  // against the tick counter.
  localparam logic [7:0] GREEN_LAST  = 8'(MIN_GREEN_TICKS - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] COUNT_MAX   = 8'hFF;

  state_t     state;
  state_t     next_state;
  logic [7:0] count;
  logic [7:0] next_count;
  logic       green_done;
  logic       yellow_done;
  logic [7:0] green_count;

  // A green phase may end only once its minimum length has been reached.
  // The counter saturates in green, so a long hold cannot wrap back below
  // the minimum.
  assign green_done  = (count >= GREEN_LAST);
  assign yellow_done = (count == YELLOW_LAST);
  assign green_count = (count == COUNT_MAX) ? count : count + 8'd1;

  // State and tick-counter registers, with synchronous reset to A-green.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      count <= 8'd0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Next-state logic. It only acts on tick cycles, so sensor activity
  // between ticks is ignored. Every transition restarts the phase counter.
  always_comb begin
    next_state = state;
    next_count = count;
    if (tick) begin
      case (state)
        S0: begin
          if (!ta && green_done) begin
            next_state = S1;
            next_count = 8'd0;
          end else begin
            next_count = green_count;
          end
        end
        S1: begin
          if (yellow_done) begin
            next_state = S2;
            next_count = 8'd0;
          end else begin
            next_count = count + 8'd1;
          end
        end
        S2: begin
          if (!tb && green_done) begin
            next_state = S3;
            next_count = 8'd0;
          end else begin
            next_count = green_count;
          end
        end
        S3: begin
          if (yellow_done) begin
            next_state = S0;
            next_count = 8'd0;
          end else begin
            next_count = count + 8'd1;
          end
        end
        default: begin
          next_state = S0;
          next_count = 8'd0;
        end
      endcase
    end
  end

  // Light decode depends only on the state register. No state shows a
  // non-red light on both streets.
  always_comb begin
    la = RED;
    lb = RED;
    case (state)
      S0: begin
        la = GREEN;
        lb = RED;
      end
      S1: begin
        la = YELLOW;
        lb = RED;
      end
      S2: begin
        la = RED;
        lb = GREEN;
      end
      S3: begin
        la = RED;
        lb = YELLOW;
      end
      default: begin
        la = RED;
        lb = RED;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with YELLOW_TICKS=3 and
// MIN_GREEN_TICKS=2. A tick arrives on every third cycle. Expected states
// and lights are hand-derived constants. A random phase at the end checks
// the light-safety rules on every cycle.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       ta = 1'b0;
  logic       tb = 1'b0;
  logic [1:0] la;
  logic [1:0] lb;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  traffic_light_ctrl #(
    .YELLOW_TICKS(3),
    .MIN_GREEN_TICKS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .ta(ta),
    .tb(tb),
    .la(la),
    .lb(lb),
    .state_o(state_o)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic tk,
                               input logic a, input logic b);
    reset = rst;
    tick  = tk;
    ta    = a;
    tb    = b;
    @(posedge clk);
    #1;
  endtask

  // Run one tick period: two idle cycles, then one tick cycle. The sensor
  // values can differ between the idle cycles and the tick cycle.
  task automatic tickPeriod(input logic idle_a, input logic idle_b,
                            input logic tick_a, input logic tick_b);
    applyStimulus(1'b0, 1'b0, idle_a, idle_b);
    applyStimulus(1'b0, 1'b0, idle_a, idle_b);
    applyStimulus(1'b0, 1'b1, tick_a, tick_b);
  endtask

  // Compare the state code and both lights against the fixed light table.
  task automatic checkState(input string tag, input logic [1:0] s);
    logic [1:0] exp_la;
    logic [1:0] exp_lb;
    case (s)
      2'd0: begin exp_la = 2'b00; exp_lb = 2'b10; end
      2'd1: begin exp_la = 2'b01; exp_lb = 2'b10; end
      2'd2: begin exp_la = 2'b10; exp_lb = 2'b00; end
      default: begin exp_la = 2'b10; exp_lb = 2'b01; end
    endcase
    checkOutput({tag, "_state"}, 8'(state_o), 8'(s));
    checkOutput({tag, "_la"}, 8'(la), 8'(exp_la));
    checkOutput({tag, "_lb"}, 8'(lb), 8'(exp_lb));
  endtask

  // Directed scenarios, then the random safety run.
  initial begin
    logic [1:0] basic_seq [10];
    logic [1:0] prev;
    basic_seq = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};

    $display("[TB] start");

    // Reset state.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("reset", 2'd0);

    // Basic cycle: S0 2 ticks, S1 3, S2 2, S3 3, then back to S0.
    // State must hold during the idle cycles that precede each tick.
    prev = 2'd0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("basic_hold_t%0d", i + 1), 8'(state_o), 8'(prev));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkState($sformatf("basic_t%0d", i + 1), basic_seq[i]);
      prev = basic_seq[i];
    end

    // Hold green: cars on A for 256 ticks. If the counter wrapped it would
    // read 0 here, and the release tick would then fail the minimum.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      tickPeriod(1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 19 || i == 255)
        checkState($sformatf("hold_t%0d", i + 1), 2'd0);
      else
        checkOutput("hold_state", 8'(state_o), 8'd0);
    end
    tickPeriod(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("hold_release", 2'd1);

    // Sensor glitch: A clears only between ticks, so S0 is never left.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tickPeriod(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("glitch_t%0d", i + 1), 8'(state_o), 8'd0);
    end

    // Minimum green: reach S2 with tb already low. S2 lasts exactly 2 ticks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tickPeriod(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("mingreen_enter", 2'd2);
    tickPeriod(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("mingreen_t1", 2'd2);
    tickPeriod(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("mingreen_t2", 2'd3);

    // B held green by cars, then released.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tickPeriod(1'b0, 1'b1, 1'b0, 1'b1);
    checkState("holdb_enter", 2'd2);
    for (int i = 0; i < 4; i++) tickPeriod(1'b0, 1'b1, 1'b0, 1'b1);
    checkState("holdb_held", 2'd2);
    tickPeriod(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("holdb_release", 2'd3);

    // Reset mid-yellow: one tick into S3 (counter=1), then reset together
    // with tick. With the counter cleared, S0 still needs two full ticks.
    tickPeriod(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("midyel_pre", 2'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkState("midyel_reset", 2'd0);
    tickPeriod(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("midyel_t1", 2'd0);
    tickPeriod(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("midyel_t2", 2'd1);

    // Random safety run: never green on both, always red on at least one.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("safety_not_both_green", 8'(la != 2'b00 || lb != 2'b00), 8'd1);
      checkOutput("safety_one_red", 8'(la == 2'b10 || lb == 2'b10), 8'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
